// File: rtl/ip1_test_pkg.sv
// Shared types and constants for the ip1 test sequencer and the test state machines.
package ip1_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } ctrl_state_e;

  // Pin bus field positions, MSB first: {config_clk,reset_not,config_in,config_load,vin_test_trig_out,scan_in,scan_load}
  localparam int unsigned PIN_W             = 7;
  localparam int unsigned PIN_CONFIG_CLK    = 6;
  localparam int unsigned PIN_RESET_NOT     = 5;
  localparam int unsigned PIN_CONFIG_IN     = 4;
  localparam int unsigned PIN_CONFIG_LOAD   = 3;
  localparam int unsigned PIN_VIN_TRIG_OUT  = 2;
  localparam int unsigned PIN_SCAN_IN       = 1;
  localparam int unsigned PIN_SCAN_LOAD     = 0;

  localparam logic [PIN_W-1:0] PIN_RESET_DEFAULT = 7'b0100100;

  localparam int unsigned SHIFT_CNT_W = 13;

  typedef enum logic {
    SHIFT_REG   = 1'b0,
    LOAD_CONFIG = 1'b1
  } shift_mode_e;

endpackage

// File: rtl/ip1_cfg_clk_gen.sv
// Free-running divided config clock: counter wraps at max(period,2)-1, clock high for the first half.
module ip1_cfg_clk_gen #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] period,
  output logic [W-1:0] counter,
  output logic         cfg_clk
);

  logic [W-1:0] counter_d, counter_q;
  logic [W-1:0] eff_period;
  logic         cfg_clk_d, cfg_clk_q;

  // A period change lands at the next wrap; a counter already past the new end wraps at once.
  always_comb begin
    eff_period = (period < W'(2)) ? W'(2) : period;
    counter_d  = (counter_q >= eff_period - W'(1)) ? '0 : counter_q + W'(1);
    cfg_clk_d  = (counter_d < (eff_period >> 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= '0;
      cfg_clk_q <= 1'b0;
    end else begin
      counter_q <= counter_d;
      cfg_clk_q <= cfg_clk_d;
    end
  end

  assign counter = counter_q;
  assign cfg_clk = cfg_clk_q;

endmodule

// File: rtl/ip1_test_ctrl.sv
// Arbitrates the shared ASIC config pins and shift register between the ip1 test state machines.
module ip1_test_ctrl
  import ip1_test_pkg::*;
#(
  parameter int unsigned N_TESTS = 4,
  parameter int unsigned TMO_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_start,
  input  logic                   cfg_abort,
  input  logic [3:0]             cfg_test_sel,
  input  logic [6:0]             cfg_fc_period,
  input  logic [26:0]            cfg_sc_period,
  input  logic [TMO_W-1:0]       cfg_timeout,
  output logic [6:0]             clk_counter_fc,
  output logic [26:0]            clk_counter_sc,
  output logic                   fast_config_clk,
  output logic                   slow_config_clk,
  output logic [N_TESTS-1:0]     test_enable,
  output logic [N_TESTS-1:0]     test_start_re,
  input  logic [7*N_TESTS-1:0]   test_pins,
  input  logic [2*N_TESTS-1:0]   test_shift_ctl,
  input  logic [N_TESTS-1:0]     test_done,
  output logic                   shift_reg_load,
  output logic                   shift_reg_shift,
  output logic [12:0]            shift_cnt,
  output logic [6:0]             asic_pins,
  output logic [2:0]             ctrl_state,
  output logic                   status_busy,
  output logic                   status_done,
  output logic                   status_timeout,
  output logic                   status_aborted,
  output logic                   status_sel_err
);

  ip1_cfg_clk_gen #(.W(7)) u_fc_gen (
    .clk(clk), .reset(reset), .period(cfg_fc_period),
    .counter(clk_counter_fc), .cfg_clk(fast_config_clk)
  );

  ip1_cfg_clk_gen #(.W(27)) u_sc_gen (
    .clk(clk), .reset(reset), .period(cfg_sc_period),
    .counter(clk_counter_sc), .cfg_clk(slow_config_clk)
  );

  ctrl_state_e            state_d, state_q;
  logic [3:0]             sel_d, sel_q;
  logic [TMO_W-1:0]       tmo_d, tmo_q;
  logic                   start_prev_d, start_prev_q;
  logic                   abort_prev_d, abort_prev_q;
  logic [N_TESTS-1:0]     done_prev_d, done_prev_q;
  logic                   done_d, done_q, timeout_d, timeout_q;
  logic                   aborted_d, aborted_q, sel_err_d, sel_err_q;
  logic [SHIFT_CNT_W-1:0] shift_cnt_d, shift_cnt_q;
  logic [PIN_W-1:0]       asic_pins_d, asic_pins_q;

  logic                   start_re, abort_re, done_re, sel_valid, active;
  logic [N_TESTS-1:0]     sel_onehot;
  logic [PIN_W-1:0]       pins_sel;
  logic                   load_sel, shift_sel, done_sel, done_prev_sel;

  always_comb begin
    sel_onehot    = '0;
    pins_sel      = '0;
    load_sel      = 1'b0;
    shift_sel     = 1'b0;
    done_sel      = 1'b0;
    done_prev_sel = 1'b0;
    for (int unsigned k = 0; k < N_TESTS; k++) begin
      if (sel_q == 4'(k + 1)) begin
        sel_onehot[k] = 1'b1;
        pins_sel      = test_pins[7*k +: 7];
        load_sel      = test_shift_ctl[2*k+1];
        shift_sel     = test_shift_ctl[2*k];
        done_sel      = test_done[k];
        done_prev_sel = done_prev_q[k];
      end
    end
  end

  assign start_re  = cfg_start & ~start_prev_q;
  assign abort_re  = cfg_abort & ~abort_prev_q;
  assign done_re   = done_sel & ~done_prev_sel;
  assign sel_valid = (cfg_test_sel != 4'd0) && (32'(cfg_test_sel) <= N_TESTS);
  assign active    = (state_q == ST_ARM) || (state_q == ST_START) || (state_q == ST_RUN);

  // Enables and strobes are gated by reset so they drop in the cycle reset is sampled.
  assign test_enable     = (active && !reset) ? sel_onehot : '0;
  assign test_start_re   = ((state_q == ST_START) && !reset) ? sel_onehot : '0;
  assign shift_reg_load  = active & ~reset & load_sel;
  assign shift_reg_shift = active & ~reset & shift_sel;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    tmo_d        = tmo_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    aborted_d    = aborted_q;
    sel_err_d    = sel_err_q;
    start_prev_d = cfg_start;
    abort_prev_d = cfg_abort;
    done_prev_d  = test_done;

    case (state_q)
      ST_IDLE: begin
        if (start_re) begin
          if (sel_valid) begin
            sel_d     = cfg_test_sel;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            aborted_d = 1'b0;
            sel_err_d = 1'b0;
            state_d   = ST_ARM;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      ST_ARM: begin
        tmo_d   = '0;
        state_d = ST_START;
      end
      ST_START: begin
        tmo_d   = tmo_q + TMO_W'(1);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (!abort_re) begin
          if (done_re) begin
            state_d = ST_DONE;
          end else if ((cfg_timeout != '0) && (tmo_q == cfg_timeout)) begin
            timeout_d = 1'b1;
            state_d   = ST_ABORT;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (active && abort_re) begin
      aborted_d = 1'b1;
      state_d   = ST_ABORT;
    end
  end

  always_comb begin
    shift_cnt_d = shift_cnt_q;
    if (shift_reg_load) begin
      shift_cnt_d = '0;
    end else if (shift_reg_shift && (shift_cnt_q != '1)) begin
      shift_cnt_d = shift_cnt_q + SHIFT_CNT_W'(1);
    end
    asic_pins_d = active ? pins_sel : PIN_RESET_DEFAULT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      tmo_q        <= '0;
      start_prev_q <= 1'b0;
      abort_prev_q <= 1'b0;
      done_prev_q  <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      aborted_q    <= 1'b0;
      sel_err_q    <= 1'b0;
      shift_cnt_q  <= '0;
      asic_pins_q  <= PIN_RESET_DEFAULT;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      tmo_q        <= tmo_d;
      start_prev_q <= start_prev_d;
      abort_prev_q <= abort_prev_d;
      done_prev_q  <= done_prev_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      aborted_q    <= aborted_d;
      sel_err_q    <= sel_err_d;
      shift_cnt_q  <= shift_cnt_d;
      asic_pins_q  <= asic_pins_d;
    end
  end

  assign shift_cnt      = shift_cnt_q;
  assign asic_pins      = asic_pins_q;
  assign ctrl_state     = state_q;
  assign status_busy    = (state_q != ST_IDLE);
  assign status_done    = done_q;
  assign status_timeout = timeout_q;
  assign status_aborted = aborted_q;
  assign status_sel_err = sel_err_q;

endmodule

// File: tb/tb_ip1_test_ctrl.sv
// Directed-vector bench for ip1_test_ctrl: clock generation, run/done, shift count, timeout, abort, pins, reset.
module tb_ip1_test_ctrl;

  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_start, cfg_abort;
  logic [3:0]    cfg_test_sel;
  logic [6:0]    cfg_fc_period;
  logic [26:0]   cfg_sc_period;
  logic [31:0]   cfg_timeout;
  logic [6:0]    clk_counter_fc;
  logic [26:0]   clk_counter_sc;
  logic          fast_config_clk, slow_config_clk;
  logic [N-1:0]  test_enable, test_start_re;
  logic [7*N-1:0] test_pins;
  logic [2*N-1:0] test_shift_ctl;
  logic [N-1:0]  test_done;
  logic          shift_reg_load, shift_reg_shift;
  logic [12:0]   shift_cnt;
  logic [6:0]    asic_pins;
  logic [2:0]    ctrl_state;
  logic          status_busy, status_done, status_timeout, status_aborted, status_sel_err;

  int n_vec = 0;
  int n_err = 0;

  ip1_test_ctrl #(.N_TESTS(N), .TMO_W(32)) dut (
    .clk(clk), .reset(reset),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_test_sel(cfg_test_sel),
    .cfg_fc_period(cfg_fc_period), .cfg_sc_period(cfg_sc_period), .cfg_timeout(cfg_timeout),
    .clk_counter_fc(clk_counter_fc), .clk_counter_sc(clk_counter_sc),
    .fast_config_clk(fast_config_clk), .slow_config_clk(slow_config_clk),
    .test_enable(test_enable), .test_start_re(test_start_re),
    .test_pins(test_pins), .test_shift_ctl(test_shift_ctl), .test_done(test_done),
    .shift_reg_load(shift_reg_load), .shift_reg_shift(shift_reg_shift), .shift_cnt(shift_cnt),
    .asic_pins(asic_pins), .ctrl_state(ctrl_state), .status_busy(status_busy),
    .status_done(status_done), .status_timeout(status_timeout),
    .status_aborted(status_aborted), .status_sel_err(status_sel_err)
  );

  always #5 clk = ~clk;

  task automatic start_test(input logic [3:0] sel);
    cfg_test_sel = sel;
    cfg_start    = 1'b1;
    repeat (3) @(negedge clk);
    cfg_start    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_test_sel = '0;
    cfg_fc_period = 7'd10; cfg_sc_period = 27'd4; cfg_timeout = '0;
    test_pins = '0; test_shift_ctl = '0; test_done = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (clk_counter_fc !== 7'd0 || clk_counter_sc !== 27'd0) begin n_err++; $display("FAIL reset_counters: fc=%0d sc=%0d expected 0 0", clk_counter_fc, clk_counter_sc); end
    n_vec++; if (fast_config_clk !== 1'b0 || slow_config_clk !== 1'b0) begin n_err++; $display("FAIL reset_clocks: fc=%b sc=%b expected 0 0", fast_config_clk, slow_config_clk); end
    n_vec++; if (test_enable !== 4'b0 || test_start_re !== 4'b0) begin n_err++; $display("FAIL reset_enables: en=%b sre=%b expected 0000 0000", test_enable, test_start_re); end
    n_vec++; if (shift_reg_load !== 1'b0 || shift_reg_shift !== 1'b0 || shift_cnt !== 13'd0) begin n_err++; $display("FAIL reset_shift: load=%b shift=%b cnt=%0d expected 0 0 0", shift_reg_load, shift_reg_shift, shift_cnt); end
    n_vec++; if (asic_pins !== 7'b0100100) begin n_err++; $display("FAIL reset_pins: got %b expected 0100100", asic_pins); end
    n_vec++; if (ctrl_state !== 3'd0 || status_busy !== 1'b0) begin n_err++; $display("FAIL reset_state: state=%0d busy=%b expected 0 0", ctrl_state, status_busy); end
    n_vec++; if ({status_done, status_timeout, status_aborted, status_sel_err} !== 4'b0) begin n_err++; $display("FAIL reset_status: got %b expected 0000", {status_done, status_timeout, status_aborted, status_sel_err}); end
    reset = 1'b0;
  endtask

  task automatic test_clk_gen();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin @(negedge clk); if (clk_counter_fc === 7'd9) found = 1'b1; end
    n_vec++; if (!found) begin n_err++; $display("FAIL fc_wait_wrap: counter=%0d never reached 9", clk_counter_fc); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (clk_counter_fc !== 7'(i % 10) || fast_config_clk !== ((i % 10) < 5)) begin
        n_err++; $display("FAIL fc_period10 step %0d: cnt=%0d clk=%b expected %0d %b", i, clk_counter_fc, fast_config_clk, i % 10, (i % 10) < 5);
      end
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin @(negedge clk); if (clk_counter_sc === 27'd3) found = 1'b1; end
    n_vec++; if (!found) begin n_err++; $display("FAIL sc_wait_wrap: counter=%0d never reached 3", clk_counter_sc); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_vec++;
      if (clk_counter_sc !== 27'(i % 4) || slow_config_clk !== ((i % 4) < 2)) begin
        n_err++; $display("FAIL sc_period4 step %0d: cnt=%0d clk=%b expected %0d %b", i, clk_counter_sc, slow_config_clk, i % 4, (i % 4) < 2);
      end
    end
    cfg_fc_period = 7'd1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); if (clk_counter_fc === 7'd1) found = 1'b1; end
    n_vec++; if (!found) begin n_err++; $display("FAIL fc_period1_wait: counter=%0d never reached 1", clk_counter_fc); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if (clk_counter_fc !== 7'(i % 2) || fast_config_clk !== ((i % 2) == 0)) begin
        n_err++; $display("FAIL fc_period1 step %0d: cnt=%0d clk=%b expected %0d %b", i, clk_counter_fc, fast_config_clk, i % 2, (i % 2) == 0);
      end
    end
    cfg_fc_period = 7'd10;
  endtask

  task automatic test_run_done();
    cfg_test_sel = 4'd2;
    cfg_start    = 1'b1;
    @(negedge clk);
    n_vec++; if (ctrl_state !== 3'd1 || test_enable !== 4'b0010 || test_start_re !== 4'b0000) begin n_err++; $display("FAIL run_arm: state=%0d en=%b sre=%b expected 1 0010 0000", ctrl_state, test_enable, test_start_re); end
    @(negedge clk);
    n_vec++; if (ctrl_state !== 3'd2 || test_enable !== 4'b0010 || test_start_re !== 4'b0010) begin n_err++; $display("FAIL run_start: state=%0d en=%b sre=%b expected 2 0010 0010", ctrl_state, test_enable, test_start_re); end
    @(negedge clk);
    cfg_start = 1'b0;
    n_vec++; if (ctrl_state !== 3'd3 || test_enable !== 4'b0010 || test_start_re !== 4'b0000 || status_busy !== 1'b1) begin n_err++; $display("FAIL run_enter: state=%0d en=%b sre=%b busy=%b expected 3 0010 0000 1", ctrl_state, test_enable, test_start_re, status_busy); end
    repeat (50) @(negedge clk);
    n_vec++; if (ctrl_state !== 3'd3 || status_done !== 1'b0) begin n_err++; $display("FAIL run_hold: state=%0d done=%b expected 3 0", ctrl_state, status_done); end
    test_done = 4'b0010;
    @(negedge clk);
    n_vec++; if (ctrl_state !== 3'd4 || test_enable !== 4'b0000) begin n_err++; $display("FAIL run_done_state: state=%0d en=%b expected 4 0000", ctrl_state, test_enable); end
    @(negedge clk);
    n_vec++; if (ctrl_state !== 3'd0 || status_done !== 1'b1 || test_enable !== 4'b0000 || status_busy !== 1'b0) begin n_err++; $display("FAIL run_done_idle: state=%0d done=%b en=%b busy=%b expected 0 1 0000 0", ctrl_state, status_done, test_enable, status_busy); end
    test_done = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_shift();
    start_test(4'd1);
    test_shift_ctl = 8'b0000_0010;
    #1;
    n_vec++; if (shift_reg_load !== 1'b1 || shift_reg_shift !== 1'b0) begin n_err++; $display("FAIL shift_mux_load: load=%b shift=%b expected 1 0", shift_reg_load, shift_reg_shift); end
    @(negedge clk);
    n_vec++; if (shift_cnt !== 13'd0) begin n_err++; $display("FAIL shift_after_load: cnt=%0d expected 0", shift_cnt); end
    test_shift_ctl = 8'b0000_0001;
    #1;
    n_vec++; if (shift_reg_load !== 1'b0 || shift_reg_shift !== 1'b1) begin n_err++; $display("FAIL shift_mux_shift: load=%b shift=%b expected 0 1", shift_reg_load, shift_reg_shift); end
    repeat (768) @(negedge clk);
    test_shift_ctl = 8'b0;
    n_vec++; if (shift_cnt !== 13'd768) begin n_err++; $display("FAIL shift_768: cnt=%0d expected 768", shift_cnt); end
    @(negedge clk);
    n_vec++; if (shift_cnt !== 13'd768) begin n_err++; $display("FAIL shift_hold: cnt=%0d expected 768", shift_cnt); end
    test_shift_ctl = 8'b0000_0011;
    @(negedge clk);
    test_shift_ctl = 8'b0;
    n_vec++; if (shift_cnt !== 13'd0) begin n_err++; $display("FAIL shift_load_wins: cnt=%0d expected 0", shift_cnt); end
    test_shift_ctl = 8'b0000_0001;
    repeat (9000) @(negedge clk);
    test_shift_ctl = 8'b0;
    n_vec++; if (shift_cnt !== 13'd8191) begin n_err++; $display("FAIL shift_saturate: cnt=%0d expected 8191", shift_cnt); end
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    n_vec++; if (ctrl_state !== 3'd5 || test_enable !== 4'b0) begin n_err++; $display("FAIL shift_abort_state: state=%0d en=%b expected 5 0000", ctrl_state, test_enable); end
    @(negedge clk);
    n_vec++; if (ctrl_state !== 3'd0 || status_aborted !== 1'b1) begin n_err++; $display("FAIL shift_abort_idle: state=%0d aborted=%b expected 0 1", ctrl_state, status_aborted); end
    test_shift_ctl = 8'b0000_0011;
    #1;
    n_vec++; if (shift_reg_load !== 1'b0 || shift_reg_shift !== 1'b0) begin n_err++; $display("FAIL shift_idle_gate: load=%b shift=%b expected 0 0", shift_reg_load, shift_reg_shift); end
    @(negedge clk);
    test_shift_ctl = 8'b0;
    n_vec++; if (shift_cnt !== 13'd8191) begin n_err++; $display("FAIL shift_idle_hold: cnt=%0d expected 8191", shift_cnt); end
  endtask

  task automatic test_timeout();
    int cyc;
    cfg_timeout = 32'd100;
    start_test(4'd3);
    cyc = 0;
    while (ctrl_state !== 3'd5 && cyc < 300) begin @(negedge clk); cyc++; end
    n_vec++; if (ctrl_state !== 3'd5) begin n_err++; $display("FAIL tmo_reach_abort: state=%0d after %0d cycles expected 5", ctrl_state, cyc); end
    n_vec++; if (cyc !== 100) begin n_err++; $display("FAIL tmo_latency: %0d RUN cycles expected 100", cyc); end
    n_vec++; if (test_enable !== 4'b0 || status_timeout !== 1'b1) begin n_err++; $display("FAIL tmo_abort_out: en=%b timeout=%b expected 0000 1", test_enable, status_timeout); end
    @(negedge clk);
    n_vec++; if (ctrl_state !== 3'd0 || {status_done, status_timeout, status_aborted} !== 3'b010) begin n_err++; $display("FAIL tmo_idle: state=%0d dta=%b expected 0 010", ctrl_state, {status_done, status_timeout, status_aborted}); end
    cfg_timeout = 32'd0;
    start_test(4'd4);
    repeat (300) @(negedge clk);
    n_vec++; if (ctrl_state !== 3'd3 || test_enable !== 4'b1000 || status_timeout !== 1'b0) begin n_err++; $display("FAIL tmo_disabled: state=%0d en=%b timeout=%b expected 3 1000 0", ctrl_state, test_enable, status_timeout); end
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    @(negedge clk);
    n_vec++; if (ctrl_state !== 3'd0 || status_aborted !== 1'b1) begin n_err++; $display("FAIL tmo_disabled_abort: state=%0d aborted=%b expected 0 1", ctrl_state, status_aborted); end
  endtask

  task automatic test_abort_coincident();
    start_test(4'd2);
    repeat (20) @(negedge clk);
    cfg_abort = 1'b1;
    test_done = 4'b0010;
    @(negedge clk);
    n_vec++; if (ctrl_state !== 3'd5 || test_enable !== 4'b0) begin n_err++; $display("FAIL abort_pri_state: state=%0d en=%b expected 5 0000", ctrl_state, test_enable); end
    cfg_abort = 1'b0;
    test_done = 4'b0;
    @(negedge clk);
    n_vec++; if (ctrl_state !== 3'd0 || status_aborted !== 1'b1 || status_done !== 1'b0) begin n_err++; $display("FAIL abort_pri_status: state=%0d aborted=%b done=%b expected 0 1 0", ctrl_state, status_aborted, status_done); end
  endtask

  task automatic test_sel_err();
    cfg_test_sel = 4'd0;
    cfg_start    = 1'b1;
    @(negedge clk);
    cfg_start    = 1'b0;
    n_vec++; if (ctrl_state !== 3'd0 || status_sel_err !== 1'b1 || test_enable !== 4'b0) begin n_err++; $display("FAIL sel0_err: state=%0d err=%b en=%b expected 0 1 0000", ctrl_state, status_sel_err, test_enable); end
    @(negedge clk);
    start_test(4'd1);
    n_vec++; if (status_sel_err !== 1'b0 || status_aborted !== 1'b0 || ctrl_state !== 3'd3) begin n_err++; $display("FAIL sel_valid_clears: err=%b aborted=%b state=%0d expected 0 0 3", status_sel_err, status_aborted, ctrl_state); end
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    @(negedge clk);
    cfg_test_sel = 4'd5;
    cfg_start    = 1'b1;
    @(negedge clk);
    cfg_start    = 1'b0;
    n_vec++; if (ctrl_state !== 3'd0 || status_sel_err !== 1'b1 || test_enable !== 4'b0 || status_busy !== 1'b0) begin n_err++; $display("FAIL sel5_err: state=%0d err=%b en=%b busy=%b expected 0 1 0000 0", ctrl_state, status_sel_err, test_enable, status_busy); end
    @(negedge clk);
  endtask

  task automatic test_pins_reset();
    n_vec++; if (asic_pins !== 7'b0100100) begin n_err++; $display("FAIL pins_idle: got %b expected 0100100", asic_pins); end
    test_pins = {7'b1111111, 7'b0000000, 7'b1111111, 7'b1011010};
    start_test(4'd1);
    @(negedge clk);
    n_vec++; if (asic_pins !== 7'b1011010 || test_enable !== 4'b0001) begin n_err++; $display("FAIL pins_run: pins=%b en=%b expected 1011010 0001", asic_pins, test_enable); end
    test_pins[6:0] = 7'b0110011;
    @(negedge clk);
    n_vec++; if (asic_pins !== 7'b0110011) begin n_err++; $display("FAIL pins_follow: pins=%b expected 0110011", asic_pins); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (asic_pins !== 7'b0100100 || test_enable !== 4'b0 || test_start_re !== 4'b0 || ctrl_state !== 3'd0) begin n_err++; $display("FAIL reset_midrun: pins=%b en=%b sre=%b state=%0d expected 0100100 0000 0000 0", asic_pins, test_enable, test_start_re, ctrl_state); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clk_gen();
    test_run_done();
    test_shift();
    test_timeout();
    test_abort_coincident();
    test_sel_err();
    test_pins_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
